// File: rtl/autoconfig_pkg.sv
// autoconfig_pkg: shared constants, state enums and helpers for the Zorro II
// AutoConfig enumerator.
//   - config space register word offsets (ADDR[8:1]) and the $E8 page
//   - memory / I/O pool limits in 64K units (A[23:16])
//   - size-code to 64K-unit conversion and config-space address builder
//   - FSM state enums for the bus-cycle engine and the enumerator
package autoconfig_pkg;

    localparam logic [7:0] CFG_PAGE     = 8'hE8;

    localparam logic [7:0] OFF_TYPE_HI  = 8'h00;
    localparam logic [7:0] OFF_TYPE_LO  = 8'h01;
    localparam logic [7:0] OFF_PROD_HI  = 8'h02;
    localparam logic [7:0] OFF_PROD_LO  = 8'h03;
    localparam logic [7:0] OFF_MFG_3    = 8'h08;
    localparam logic [7:0] OFF_MFG_2    = 8'h09;
    localparam logic [7:0] OFF_MFG_1    = 8'h0A;
    localparam logic [7:0] OFF_MFG_0    = 8'h0B;
    localparam logic [7:0] OFF_BASE_HI  = 8'h24;
    localparam logic [7:0] OFF_BASE_LO  = 8'h25;
    localparam logic [7:0] OFF_SHUTUP   = 8'h26;

    localparam logic [7:0] MEM_POOL_START = 8'h20;
    localparam logic [8:0] MEM_POOL_END   = 9'h0A0;
    localparam logic [7:0] IO_POOL_START  = 8'hE9;
    localparam logic [8:0] IO_POOL_END    = 9'h0F0;

    typedef enum logic [1:0] {
        S_ADDR,
        S_WAIT,
        S_END,
        S_GAP
    } bus_state_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_T0,
        ST_RD_T1,
        ST_RD_P0,
        ST_RD_P1,
        ST_RD_M0,
        ST_RD_M1,
        ST_RD_M2,
        ST_RD_M3,
        ST_ALLOC,
        ST_WR_LO,
        ST_WR_HI,
        ST_SHUT,
        ST_REPORT,
        ST_FINISH
    } host_state_t;

    // Size code 000 is the 8 MB board (128 units); 001..111 double from 64K.
    function automatic logic [7:0] size_units(input logic [2:0] code);
        if (code == 3'd0)
            return 8'd128;
        return 8'd1 << (code - 3'd1);
    endfunction

    function automatic logic [22:0] cfg_addr(input logic [7:0] off);
        return {CFG_PAGE, 7'd0, off};
    endfunction

endpackage

// File: rtl/zorro_bus_cycle.sv
// zorro_bus_cycle: runs one Zorro II read or write cycle per request.
//   clk_sys, rst_b       : clock, synchronous active-low reset
//   req, wr, addr, wdata : request from the enumerator, held until ack
//   ack                  : one-cycle pulse in S_GAP, rdata/timeout valid
//   rdata, timeout       : nibble captured on DTACK, or no-response flag
//   bus_addr, as_n, rw, dout, din, dtack : bus pins
//
// state  | meaning
// S_ADDR | idle / address phase: bus lines valid, as_n high
// S_WAIT | as_n low, waiting for dtack or timeout
// S_END  | as_n high again (responders advance on this edge)
// S_GAP  | as_n high, ack to requester
module zorro_bus_cycle
    import autoconfig_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        req,
    input  logic        wr,
    input  logic [22:0] addr,
    input  logic [3:0]  wdata,
    output logic        ack,
    output logic [3:0]  rdata,
    output logic        timeout,
    output logic [22:0] bus_addr,
    output logic        as_n,
    output logic        rw,
    output logic [3:0]  dout,
    input  logic [3:0]  din,
    input  logic        dtack
);

    localparam int TW = $clog2(TIMEOUT + 1);

    bus_state_t    state, state_next;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk_sys) begin
        if (!rst_b)
            state <= S_ADDR;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_ADDR: if (req) state_next = S_WAIT;
            S_WAIT: if (dtack || tcnt == '0) state_next = S_END;
            S_END:  state_next = S_GAP;
            S_GAP:  state_next = S_ADDR;
            default: state_next = S_ADDR;
        endcase
    end

    // Down-counter loaded in the address phase; S_WAIT lasts at most TIMEOUT clocks.
    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            tcnt    <= '0;
            rdata   <= '0;
            timeout <= 1'b0;
        end else if (state == S_ADDR) begin
            tcnt <= TW'(TIMEOUT - 1);
        end else if (state == S_WAIT) begin
            if (dtack) begin
                rdata   <= din;
                timeout <= 1'b0;
            end else if (tcnt == '0) begin
                timeout <= 1'b1;
            end else begin
                tcnt <= tcnt - 1'b1;
            end
        end
    end

    assign ack      = (state == S_GAP);
    assign as_n     = (state != S_WAIT);
    assign bus_addr = addr;
    assign rw       = ~wr;
    assign dout     = wdata;

endmodule

// File: rtl/autoconfig_host.sv
// autoconfig_host: Zorro II AutoConfig enumerator. On start it walks the
// $E8 config chain, reads type/product/manufacturer, allocates a base from the
// memory or I/O pool and writes it, or shuts up a board that does not fit.
//   CLK, RESET_n          : clock, synchronous active-low reset
//   start                 : begins enumeration when not busy
//   ADDR, AS_n, RW, DOUT  : bus outputs (ADDR = A[23:1], DOUT = D[15:12])
//   DIN, DTACK            : read nibble and acknowledge from the board
//   busy, done            : in progress / finished (sticky until next start)
//   board_count           : boards configured or shut up
//   cfg_valid + cfg_*     : per-board result, cfg_valid is a one-cycle pulse
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_RD_T0  | read er_Type high nibble; empty chain ends here
// ST_RD_T1  | read er_Type low nibble (size code)
// ST_RD_P*  | read product nibbles (inverted)
// ST_RD_M*  | read manufacturer nibbles 15:12..3:0 (inverted)
// ST_ALLOC  | size, align and fit-check against the pool
// ST_WR_LO  | write base[3:0] at $25
// ST_WR_HI  | write base[7:4] at $24, board commits and leaves the chain
// ST_SHUT   | write shut-up at $26
// ST_REPORT | pulse cfg_valid, count the board
// ST_FINISH | enumeration over, done set
module autoconfig_host
    import autoconfig_pkg::*;
#(
    parameter int MAX_BOARDS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        start,
    output logic [22:0] ADDR,
    output logic        AS_n,
    output logic        RW,
    output logic [3:0]  DOUT,
    input  logic [3:0]  DIN,
    input  logic        DTACK,
    output logic        busy,
    output logic        done,
    output logic [2:0]  board_count,
    output logic        cfg_valid,
    output logic [15:0] cfg_mfg,
    output logic [7:0]  cfg_prod,
    output logic [7:0]  cfg_base,
    output logic        cfg_shutup
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_BOARDS);

    host_state_t state, state_next;

    logic        bus_req, bus_wr, bus_ack, bus_timeout;
    logic [7:0]  bus_off;
    logic [3:0]  bus_wdata, bus_rdata, nib;
    logic [22:0] bus_addr;

    logic        is_mem;
    logic [2:0]  size_code;
    logic [7:0]  prod, next_mem, next_io;
    logic [15:0] mfg;
    logic        start_ok;

    logic [7:0]  units;
    logic [8:0]  mask9, aligned9, end9, limit9;
    logic        fit;

    zorro_bus_cycle #(.TIMEOUT(TIMEOUT)) u_bus (
        .clk_sys  (CLK),
        .rst_b    (RESET_n),
        .req      (bus_req),
        .wr       (bus_wr),
        .addr     (bus_addr),
        .wdata    (bus_wdata),
        .ack      (bus_ack),
        .rdata    (bus_rdata),
        .timeout  (bus_timeout),
        .bus_addr (ADDR),
        .as_n     (AS_n),
        .rw       (RW),
        .dout     (DOUT),
        .din      (DIN),
        .dtack    (DTACK)
    );

    // A read with no response looks like an undriven bus.
    assign nib      = bus_timeout ? 4'hF : bus_rdata;
    assign bus_addr = bus_req ? cfg_addr(bus_off) : '0;
    assign start_ok = start && (state == ST_IDLE || state == ST_FINISH);
    assign busy     = (state != ST_IDLE) && (state != ST_FINISH);
    assign cfg_valid = (state == ST_REPORT);

    // Allocation in 9 bits so alignment past $FF cannot wrap into a fit.
    always_comb begin
        units    = size_units(size_code);
        mask9    = {1'b0, units} - 9'd1;
        limit9   = is_mem ? MEM_POOL_END : IO_POOL_END;
        aligned9 = ({1'b0, (is_mem ? next_mem : next_io)} + mask9) & ~mask9;
        if (is_mem && size_code == 3'd0)
            aligned9 = {1'b0, MEM_POOL_START};
        end9 = aligned9 + {1'b0, units};
        fit  = (end9 <= limit9);
        if (is_mem && size_code == 3'd0 && next_mem != MEM_POOL_START)
            fit = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        bus_wr     = 1'b0;
        bus_off    = 8'h00;
        bus_wdata  = 4'h0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RD_T0;
            end
            ST_RD_T0: begin
                bus_req = 1'b1;
                bus_off = OFF_TYPE_HI;
                if (bus_ack)
                    state_next = (bus_timeout || nib[3:2] != 2'b11) ? ST_FINISH : ST_RD_T1;
            end
            ST_RD_T1: begin
                bus_req = 1'b1;
                bus_off = OFF_TYPE_LO;
                if (bus_ack) state_next = ST_RD_P0;
            end
            ST_RD_P0: begin
                bus_req = 1'b1;
                bus_off = OFF_PROD_HI;
                if (bus_ack) state_next = ST_RD_P1;
            end
            ST_RD_P1: begin
                bus_req = 1'b1;
                bus_off = OFF_PROD_LO;
                if (bus_ack) state_next = ST_RD_M0;
            end
            ST_RD_M0: begin
                bus_req = 1'b1;
                bus_off = OFF_MFG_3;
                if (bus_ack) state_next = ST_RD_M1;
            end
            ST_RD_M1: begin
                bus_req = 1'b1;
                bus_off = OFF_MFG_2;
                if (bus_ack) state_next = ST_RD_M2;
            end
            ST_RD_M2: begin
                bus_req = 1'b1;
                bus_off = OFF_MFG_1;
                if (bus_ack) state_next = ST_RD_M3;
            end
            ST_RD_M3: begin
                bus_req = 1'b1;
                bus_off = OFF_MFG_0;
                if (bus_ack) state_next = ST_ALLOC;
            end
            ST_ALLOC: begin
                state_next = fit ? ST_WR_LO : ST_SHUT;
            end
            ST_WR_LO: begin
                bus_req   = 1'b1;
                bus_wr    = 1'b1;
                bus_off   = OFF_BASE_LO;
                bus_wdata = cfg_base[3:0];
                if (bus_ack) state_next = ST_WR_HI;
            end
            ST_WR_HI: begin
                bus_req   = 1'b1;
                bus_wr    = 1'b1;
                bus_off   = OFF_BASE_HI;
                bus_wdata = cfg_base[7:4];
                if (bus_ack) state_next = ST_REPORT;
            end
            ST_SHUT: begin
                bus_req = 1'b1;
                bus_wr  = 1'b1;
                bus_off = OFF_SHUTUP;
                if (bus_ack) state_next = ST_REPORT;
            end
            ST_REPORT: begin
                state_next = (board_count + 3'd1 == MAX_CNT) ? ST_FINISH : ST_RD_T0;
            end
            ST_FINISH: begin
                state_next = start ? ST_RD_T0 : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            done        <= 1'b0;
            board_count <= '0;
            is_mem      <= 1'b0;
            size_code   <= '0;
            prod        <= '0;
            mfg         <= '0;
            next_mem    <= MEM_POOL_START;
            next_io     <= IO_POOL_START;
            cfg_mfg     <= '0;
            cfg_prod    <= '0;
            cfg_base    <= '0;
            cfg_shutup  <= 1'b0;
        end else begin
            if (start_ok) begin
                done        <= 1'b0;
                board_count <= '0;
                next_mem    <= MEM_POOL_START;
                next_io     <= IO_POOL_START;
            end else if (state == ST_FINISH) begin
                done <= 1'b1;
            end

            if (bus_ack) begin
                case (state)
                    ST_RD_T0: is_mem       <= nib[1];
                    ST_RD_T1: size_code    <= nib[2:0];
                    ST_RD_P0: prod[7:4]    <= ~nib;
                    ST_RD_P1: prod[3:0]    <= ~nib;
                    ST_RD_M0: mfg[15:12]   <= ~nib;
                    ST_RD_M1: mfg[11:8]    <= ~nib;
                    ST_RD_M2: mfg[7:4]     <= ~nib;
                    ST_RD_M3: mfg[3:0]     <= ~nib;
                    default: ;
                endcase
            end

            if (state == ST_ALLOC) begin
                cfg_mfg    <= mfg;
                cfg_prod   <= prod;
                cfg_base   <= fit ? aligned9[7:0] : 8'h00;
                cfg_shutup <= ~fit;
                if (fit && is_mem)
                    next_mem <= end9[7:0];
                if (fit && !is_mem)
                    next_io <= end9[7:0];
            end

            if (state == ST_REPORT)
                board_count <= board_count + 3'd1;
        end
    end

endmodule

// File: tb/tb_autoconfig_host.sv
module tb_autoconfig_host;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        start;
    logic [22:0] ADDR;
    logic        AS_n, RW;
    logic [3:0]  DOUT;
    logic [3:0]  DIN = 4'h0;
    logic        DTACK = 1'b0;
    logic        busy, done, cfg_valid, cfg_shutup;
    logic [2:0]  board_count;
    logic [15:0] cfg_mfg;
    logic [7:0]  cfg_prod, cfg_base;

    autoconfig_host #(.MAX_BOARDS(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .start(start),
        .ADDR(ADDR), .AS_n(AS_n), .RW(RW), .DOUT(DOUT),
        .DIN(DIN), .DTACK(DTACK),
        .busy(busy), .done(done), .board_count(board_count),
        .cfg_valid(cfg_valid), .cfg_mfg(cfg_mfg), .cfg_prod(cfg_prod),
        .cfg_base(cfg_base), .cfg_shutup(cfg_shutup)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Chain model: written by the main block between runs only.
    logic [7:0]  b_type [8];
    logic [15:0] b_mfg  [8];
    logic [7:0]  b_prod [8];
    int nboards = 0;
    int lat = 0;
    int clear_req = 0;

    // Owned by the responder/monitor process.
    int cur = 0, nw = 0, rep_n = 0, as_cnt = 0, clear_seen = 0;
    logic as_low_prev = 1'b0, adv_pend = 1'b0;
    logic [26:0] wlog [32];
    logic [7:0]  rep_base [8];
    logic        rep_shut [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nib(input int b, input logic [7:0] off);
        logic [7:0]  t;
        logic [7:0]  p;
        logic [15:0] m;
        t = b_type[b];
        p = ~b_prod[b];
        m = ~b_mfg[b];
        case (off)
            8'h00: return t[7:4];
            8'h01: return t[3:0];
            8'h02: return p[7:4];
            8'h03: return p[3:0];
            8'h08: return m[15:12];
            8'h09: return m[11:8];
            8'h0A: return m[7:4];
            8'h0B: return m[3:0];
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [26:0] wexp(input logic [7:0] off, input logic [3:0] d);
        return {8'hE8, 7'd0, off, d};
    endfunction

    always @(negedge CLK) begin
        if (clear_req != clear_seen) begin
            cur = 0; nw = 0; rep_n = 0; as_cnt = 0;
            adv_pend = 1'b0;
            clear_seen = clear_req;
        end
        if (cfg_valid && rep_n < 8) begin
            rep_base[rep_n] = cfg_base;
            rep_shut[rep_n] = cfg_shutup;
            rep_n++;
        end
        if (!AS_n) begin
            if (!as_low_prev && !RW && nw < 32) begin
                wlog[nw] = {ADDR, DOUT};
                nw++;
                if (ADDR[7:0] == 8'h24 || ADDR[7:0] == 8'h26)
                    adv_pend = 1'b1;
            end
            DTACK = (cur < nboards) && (as_cnt >= lat);
            DIN   = (cur < nboards) ? nib(cur, ADDR[7:0]) : 4'h0;
            as_cnt++;
            as_low_prev = 1'b1;
        end else begin
            DTACK = 1'b0;
            as_cnt = 0;
            as_low_prev = 1'b0;
            if (adv_pend) begin
                cur++;
                adv_pend = 1'b0;
            end
        end
    end

    task automatic clear_chain();
        clear_req++;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!done && c < 5000) begin
            @(negedge CLK);
            c++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    initial begin
        int cyc;
        logic [26:0] e2 [6];
        RESET_n = 1'b0;
        start   = 1'b1;
        repeat (3) @(negedge CLK);
        start   = 1'b0;

        chk("rst_as_n", AS_n, 1'b1);
        chk("rst_rw", RW, 1'b1);
        chk("rst_addr", ADDR, 23'h0);
        chk("rst_dout", DOUT, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", board_count, 3'd0);
        chk("rst_cfg", {cfg_valid, cfg_mfg, cfg_prod, cfg_base, cfg_shutup}, 0);
        RESET_n = 1'b1;
        @(negedge CLK);

        // single 8 MB memory board, then empty chain
        b_type[0] = 8'hE0; b_mfg[0] = 16'h07DB; b_prod[0] = 8'h48;
        nboards = 1; lat = 0;
        clear_chain();
        start = 1'b1;
        @(posedge CLK);
        cyc = 1;
        @(negedge CLK);
        start = 1'b0;
        chk("t1_busy", busy, 1'b1);
        while (!cfg_valid && cyc < 200) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
        end
        chk("t1_latency", cyc, 42);
        chk("t1_mfg", cfg_mfg, 16'h07DB);
        chk("t1_prod", cfg_prod, 8'h48);
        chk("t1_base", cfg_base, 8'h20);
        chk("t1_shut", cfg_shutup, 1'b0);
        wait_done();
        chk("t1_count", board_count, 3'd1);
        chk("t1_nw", nw, 2);
        chk("t1_w0", wlog[0], wexp(8'h25, 4'h0));
        chk("t1_w1", wlog[1], wexp(8'h24, 4'h2));

        // 8 MB RAM, 64K I/O, 128K I/O
        b_type[0] = 8'hE0; b_mfg[0] = 16'h0202; b_prod[0] = 8'h0A;
        b_type[1] = 8'hC1; b_mfg[1] = 16'h1234; b_prod[1] = 8'h11;
        b_type[2] = 8'hD2; b_mfg[2] = 16'h4321; b_prod[2] = 8'h22;
        nboards = 3;
        clear_chain();
        pulse_start();
        chk("t2_done_clr", done, 1'b0);
        wait_done();
        chk("t2_count", board_count, 3'd3);
        chk("t2_reps", rep_n, 3);
        chk("t2_base0", rep_base[0], 8'h20);
        chk("t2_base1", rep_base[1], 8'hE9);
        chk("t2_base2", rep_base[2], 8'hEA);
        e2[0] = wexp(8'h25, 4'h0); e2[1] = wexp(8'h24, 4'h2);
        e2[2] = wexp(8'h25, 4'h9); e2[3] = wexp(8'h24, 4'hE);
        e2[4] = wexp(8'h25, 4'hA); e2[5] = wexp(8'h24, 4'hE);
        chk("t2_nw", nw, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t2_w%0d", i), wlog[i], e2[i]);

        // two 8 MB boards: second does not fit
        b_type[0] = 8'hE0; b_type[1] = 8'hE0;
        nboards = 2;
        clear_chain();
        pulse_start();
        wait_done();
        chk("t3_count", board_count, 3'd2);
        chk("t3_reps", rep_n, 2);
        chk("t3_shut0", rep_shut[0], 1'b0);
        chk("t3_shut1", rep_shut[1], 1'b1);
        chk("t3_base1", rep_base[1], 8'h00);
        chk("t3_nw", nw, 3);
        chk("t3_w2", wlog[2], wexp(8'h26, 4'h0));

        // no responder at all
        nboards = 0;
        clear_chain();
        start = 1'b1;
        @(posedge CLK);
        cyc = 1;
        @(negedge CLK);
        start = 1'b0;
        while (!done && cyc < 500) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
        end
        chk("t4_latency", cyc, 69);
        chk("t4_count", board_count, 3'd0);
        chk("t4_nw", nw, 0);
        chk("t4_reps", rep_n, 0);

        // reset while waiting on the $24 commit write
        b_type[0] = 8'hE0;
        nboards = 1; lat = 20;
        clear_chain();
        pulse_start();
        cyc = 0;
        while (!(!AS_n && ADDR[7:0] == 8'h24) && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
        end
        chk("t5_reached_wr_hi", {AS_n, ADDR[7:0]}, {1'b0, 8'h24});
        RESET_n = 1'b0;
        @(negedge CLK);
        chk("t5_as_n", AS_n, 1'b1);
        chk("t5_addr", ADDR, 23'h0);
        chk("t5_rw", RW, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_cfg_base", cfg_base, 8'h00);
        RESET_n = 1'b1;
        lat = 0;
        @(negedge CLK);
        clear_chain();
        pulse_start();
        wait_done();
        chk("t5_rerun_base", rep_base[0], 8'h20);
        chk("t5_rerun_count", board_count, 3'd1);

        // five 64K I/O boards, stray start while busy
        for (int i = 0; i < 5; i++) begin
            b_type[i] = 8'hC1; b_mfg[i] = 16'h0100 + 16'(i); b_prod[i] = 8'(i);
        end
        nboards = 5;
        clear_chain();
        pulse_start();
        repeat (60) @(negedge CLK);
        chk("t6_busy", busy, 1'b1);
        pulse_start();
        wait_done();
        chk("t6_count", board_count, 3'd4);
        chk("t6_reps", rep_n, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t6_base%0d", i), rep_base[i], 8'hE9 + 8'(i));
        chk("t6_nw", nw, 8);
        chk("t6_chain_pos", cur, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
